// File: rtl/sync_fifo.sv
// Synchronous valid/ready FIFO with show-ahead read port, almost-full flag and flush.
// Define SYNC_FIFO_COUNT_EN to drive the live occupancy on `count`; otherwise it reads zero.
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                     clock,
    input  logic                     reset_L,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             push;
    logic             pop;

    // Flags derive from registered occupancy only, so no input reaches an output combinationally.
    assign in_ready    = (occ != CW'(DEPTH));
    assign out_valid   = (occ != '0);
    assign almost_full = (occ >= CW'(AF_LEVEL));
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage is never reset; the empty-masked out_data hides stale entries.
    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= in_data;
    end

`ifdef SYNC_FIFO_COUNT_EN
    assign count = occ;
`else
    assign count = '0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue model checked every cycle plus literal spot checks.
module tb_sync_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
`ifdef SYNC_FIFO_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_L;
    logic             clear;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             almost_full;
    logic [3:0]       count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q[$];

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clock(clock), .reset_L(reset_L), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .almost_full(almost_full), .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_count(input int occ);
        return CNT_EN ? 32'(occ) : 32'd0;
    endfunction

    // Model: a plain queue updated from the handshake rules at each rising edge.
    always @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            q.delete();
        end else if (clear) begin
            q.delete();
        end else begin
            automatic bit do_push = in_valid && (q.size() != DEPTH);
            automatic bit do_pop  = out_ready && (q.size() != 0);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(in_data);
        end
    end

    always @(negedge clock) begin
        check("in_ready",    32'(in_ready),    32'(q.size() != DEPTH));
        check("out_valid",   32'(out_valid),   32'(q.size() != 0));
        check("out_data",    32'(out_data),    q.size() != 0 ? 32'(q[0]) : 32'd0);
        check("almost_full", 32'(almost_full), 32'(q.size() >= AF));
        check("count",       32'(count),       exp_count(q.size()));
    end

    task automatic push_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = base + 8'(i);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    initial begin
        reset_L = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        reset_L = 1'b1;

        // Fill 0x01..0x08, then offer 0x09 while full.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            check("fill_af", 32'(almost_full), 32'((i - 1) >= AF));
            in_valid = 1'b1;
            in_data  = 8'(i);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count",    32'(count),    exp_count(8));
        @(negedge clock);
        in_valid = 1'b0;
        check("no_9th_count", 32'(count),    exp_count(8));
        check("head_is_1",    32'(out_data), 32'h01);

        // Drain in order.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_data",  32'(out_data),  32'(i));
            check("drain_valid", 32'(out_valid), 32'd1);
            @(negedge clock);
        end
        out_ready = 1'b0;
        check("empty_valid", 32'(out_valid), 32'd0);
        check("empty_data",  32'(out_data),  32'd0);
        check("empty_count", 32'(count),     32'd0);

        // Wrap-around at occupancy 3 with concurrent push/pop.
        push_words(3, 8'h10);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("wrap_data",  32'(out_data), 32'(8'h10 + 8'(i)));
            check("wrap_count", 32'(count),    exp_count(3));
            in_data = 8'h13 + 8'(i);
            @(negedge clock);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("wrap_end_data", 32'(out_data), 32'h24);

        // Full with push and pop together: only the pop happens.
        push_words(5, 8'h30);
        check("full2_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b0;
        check("full_pop_count", 32'(count),    exp_count(7));
        check("full_pop_ready", 32'(in_ready), 32'd1);
        check("full_pop_head",  32'(out_data), 32'h25);

        // Pop two to reach 5, then clear with a simultaneous push.
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        out_ready = 1'b0;
        check("pre_clear_count", 32'(count), exp_count(5));
        clear = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clock);
        clear = 1'b0; in_valid = 1'b0;
        check("clr_count", 32'(count),     exp_count(0));
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_ready", 32'(in_ready),  32'd1);
        push_words(1, 8'h55);
        check("post_clr_data", 32'(out_data), 32'h55);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;

        // Asynchronous reset between edges at occupancy 4.
        push_words(4, 8'h60);
        check("pre_rst_count", 32'(count), exp_count(4));
        @(posedge clock);
        #3 reset_L = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready),    32'd1);
        check("arst_valid",    32'(out_valid),   32'd0);
        check("arst_data",     32'(out_data),    32'd0);
        check("arst_af",       32'(almost_full), 32'd0);
        check("arst_count",    32'(count),       32'd0);
        @(negedge clock);
        reset_L = 1'b1;
        push_words(1, 8'h77);
        check("post_rst_data",  32'(out_data), 32'h77);
        check("post_rst_count", 32'(count),    exp_count(1));
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
